// File: rtl/decode_queue_pkg.sv
// Shared fetch-entry types and widths for the decode queue slice.
// Optional same-cycle bypass is enabled with DECODE_QUEUE_BYPASS_EN.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif
`ifndef DECODE_QUEUE_DEPTH
`define DECODE_QUEUE_DEPTH 8
`endif

package decode_queue_pkg;

  localparam int INST_W   = `INST_WIDTH;
  localparam int ADDR_W   = `INST_ADDR_WIDTH;
  localparam int GHR_W    = `BP_GHR_BITS;
  localparam int BATCH    = `IF_BATCH_SIZE;
  localparam int DQ_DEPTH = `DECODE_QUEUE_DEPTH;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [GHR_W-1:0]  pred_hist;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_WIDTH = $bits(fetch_entry_t);

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and pre-decode-side bundle signals of the decode queue.
// master = surrounding pipeline, slave = the queue itself.
interface decode_queue_if;
  import decode_queue_pkg::*;

  logic [BATCH-1:0]  in_inst_valid;
  logic [INST_W-1:0] in_inst_0;
  logic [INST_W-1:0] in_inst_1;
  logic [ADDR_W-1:0] in_pc_0;
  logic [ADDR_W-1:0] in_pc_1;
  logic              in_pred_taken_0;
  logic              in_pred_taken_1;
  logic [ADDR_W-1:0] in_pred_target_0;
  logic [ADDR_W-1:0] in_pred_target_1;
  logic [GHR_W-1:0]  in_pred_hist_0;
  logic [GHR_W-1:0]  in_pred_hist_1;
  logic              in_ready;

  logic              out_stall;
  logic [BATCH-1:0]  out_inst_valid;
  logic [INST_W-1:0] out_inst_0;
  logic [INST_W-1:0] out_inst_1;
  logic [ADDR_W-1:0] out_pc_0;
  logic [ADDR_W-1:0] out_pc_1;
  logic              out_pred_taken_0;
  logic              out_pred_taken_1;
  logic [ADDR_W-1:0] out_pred_target_0;
  logic [ADDR_W-1:0] out_pred_target_1;
  logic [GHR_W-1:0]  out_pred_hist_0;
  logic [GHR_W-1:0]  out_pred_hist_1;

  modport master (
    output in_inst_valid, in_inst_0, in_inst_1,
    output in_pc_0, in_pc_1,
    output in_pred_taken_0, in_pred_taken_1,
    output in_pred_target_0, in_pred_target_1,
    output in_pred_hist_0, in_pred_hist_1,
    input  in_ready,
    output out_stall,
    input  out_inst_valid, out_inst_0, out_inst_1,
    input  out_pc_0, out_pc_1,
    input  out_pred_taken_0, out_pred_taken_1,
    input  out_pred_target_0, out_pred_target_1,
    input  out_pred_hist_0, out_pred_hist_1
  );

  modport slave (
    input  in_inst_valid, in_inst_0, in_inst_1,
    input  in_pc_0, in_pc_1,
    input  in_pred_taken_0, in_pred_taken_1,
    input  in_pred_target_0, in_pred_target_1,
    input  in_pred_hist_0, in_pred_hist_1,
    output in_ready,
    input  out_stall,
    output out_inst_valid, out_inst_0, out_inst_1,
    output out_pc_0, out_pc_1,
    output out_pred_taken_0, out_pred_taken_1,
    output out_pred_target_0, out_pred_target_1,
    output out_pred_hist_0, out_pred_hist_1
  );

endinterface

// File: rtl/decode_queue_compact.sv
// Packs the valid slots of a 2-wide fetch bundle to the front.
// Produces the entry pair and how many entries it holds.
module decode_queue_compact
  import decode_queue_pkg::*;
(
  input  logic [1:0]   mask,
  input  fetch_entry_t slot_0,
  input  fetch_entry_t slot_1,
  output fetch_entry_t ent_0,
  output fetch_entry_t ent_1,
  output logic [1:0]   n_ent
);

  always_comb begin
    ent_0 = '0;
    ent_1 = '0;
    n_ent = 2'd0;
    unique case (1'b1)
      mask == 2'b11: begin
        ent_0 = slot_0;
        ent_1 = slot_1;
        n_ent = 2'd2;
      end
      mask == 2'b01: begin
        ent_0 = slot_0;
        n_ent = 2'd1;
      end
      mask == 2'b10: begin
        ent_0 = slot_1;
        n_ent = 2'd1;
      end
      mask == 2'b00: begin
        n_ent = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-pre-decode instruction queue: compacting 2-in/2-out ring buffer.
// Define DECODE_QUEUE_BYPASS_EN for a zero-latency path when empty.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter  int DEPTH = DQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_queue_if.slave    io,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_LIM = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_1;
  logic [PTR_W-1:0] tail_1;

  fetch_entry_t slot_0, slot_1;
  fetch_entry_t cmp_0, cmp_1;
  fetch_entry_t hd_0, hd_1;
  fetch_entry_t o_0, o_1;
  logic [1:0]   n_cmp, n_enq, n_deq;
  logic [1:0]   q_valid;
  logic         enq, byp;

  assign slot_0 = '{
    inst:        io.in_inst_0,
    pc:          io.in_pc_0,
    pred_taken:  io.in_pred_taken_0,
    pred_target: io.in_pred_target_0,
    pred_hist:   io.in_pred_hist_0
  };
  assign slot_1 = '{
    inst:        io.in_inst_1,
    pc:          io.in_pc_1,
    pred_taken:  io.in_pred_taken_1,
    pred_target: io.in_pred_target_1,
    pred_hist:   io.in_pred_hist_1
  };

  decode_queue_compact u_compact (
    .mask   (io.in_inst_valid),
    .slot_0 (slot_0),
    .slot_1 (slot_1),
    .ent_0  (cmp_0),
    .ent_1  (cmp_1),
    .n_ent  (n_cmp)
  );

  // Space check uses registered count only; a same-cycle pop does not help.
  assign io.in_ready = (count <= CNT_LIM);

  assign q_valid = {count >= CNT_TWO, count != '0};

`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = (count == '0) && !io.out_stall
            && !flush && (|io.in_inst_valid);
`else
  assign byp = 1'b0;
`endif

  assign enq = io.in_ready && (|io.in_inst_valid)
            && !flush && !byp;
  assign n_enq = enq ? n_cmp : 2'd0;
  assign n_deq = (io.out_stall || flush) ? 2'd0
               : {1'b0, q_valid[0]} + {1'b0, q_valid[1]};

  assign head_1 = head + 1'b1;
  assign tail_1 = tail + 1'b1;
  assign hd_0 = q_valid[0] ? mem[head]   : '0;
  assign hd_1 = q_valid[1] ? mem[head_1] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + (PTR_W+1)'(n_enq)
                     - (PTR_W+1)'(n_deq);
      if (enq) begin
        mem[tail] <= cmp_0;
      end
      if (enq && n_cmp == 2'd2) begin
        mem[tail_1] <= cmp_1;
      end
    end
  end

  always_comb begin
    io.out_inst_valid = q_valid;
    o_0 = hd_0;
    o_1 = hd_1;
    if (byp) begin
      io.out_inst_valid = {n_cmp == 2'd2, 1'b1};
      o_0 = cmp_0;
      o_1 = cmp_1;
    end
  end

  assign io.out_inst_0        = o_0.inst;
  assign io.out_inst_1        = o_1.inst;
  assign io.out_pc_0          = o_0.pc;
  assign io.out_pc_1          = o_1.pc;
  assign io.out_pred_taken_0  = o_0.pred_taken;
  assign io.out_pred_taken_1  = o_1.pred_taken;
  assign io.out_pred_target_0 = o_0.pred_target;
  assign io.out_pred_target_1 = o_1.pred_target;
  assign io.out_pred_hist_0   = o_0.pred_hist;
  assign io.out_pred_hist_1   = o_1.pred_hist;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Instruction buffer and flow controller between the 2-wide fetch stage and the pre-decode stage.
- Accepts fetch bundles of up to `IF_BATCH_SIZE` (2) instructions with their branch-prediction metadata, and compacts out invalid slots.
- Presents the oldest two instructions in program order to pre-decode.
- Absorbs downstream stalls, raises fetch backpressure, and discards all contents on a pipeline flush.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  redirect/mispredict flush; empties the queue
- in_inst_valid  in  `IF_BATCH_SIZE  per-slot valid of the fetch bundle
- in_inst_0 / in_inst_1  in  `INST_WIDTH  instruction words
- in_pc_0 / in_pc_1  in  `INST_ADDR_WIDTH  instruction PCs
- in_pred_taken_0 / _1  in  1  predicted taken
- in_pred_target_0 / _1  in  `INST_ADDR_WIDTH  predicted target
- in_pred_hist_0 / _1  in  `BP_GHR_BITS  GHR snapshot
- in_ready  out  1  fetch may present a bundle this cycle
- out_stall  in  1  pre-decode stall; no dequeue while high
- out_inst_valid  out  `IF_BATCH_SIZE  head-slot valid
- out_inst_0/1, out_pc_0/1, out_pred_taken_0/1, out_pred_target_0/1, out_pred_hist_0/1  out  as inputs  head and head+1 entry payloads
- count  out  PTR_W+1  current occupancy

Behaviour:
- Storage: circular array of DEPTH entries. Each entry holds {inst, pc, pred_taken, pred_target, pred_hist}. Uses head/tail pointers of PTR_W bits, wrapping modulo DEPTH, plus an occupancy counter.
- Reset (async):
  - head = tail = count = 0.
  - out_inst_valid = 0; in_ready = 1.
  - All out_* payloads read 0 (entry storage cleared to 0).
- in_ready = (DEPTH − count ≥ 2). It is computed from registered count only; same-cycle dequeue does not add space.
- Enqueue happens when in_ready && |in_inst_valid && !flush. The bundle is all-or-nothing; there is no partial acceptance.
  - Mask 2'b11: slot 0 goes to tail, slot 1 to tail+1; tail += 2.
  - Mask 2'b01: slot 0 goes to tail; tail += 1.
  - Mask 2'b10: slot 1 goes to tail; tail += 1 (compaction).
  - Mask 2'b00: no write.
- When in_ready = 0, fetch must hold its bundle. Input is ignored that cycle.
- Output (combinational from storage):
  - out_inst_valid[0] = (count ≥ 1); out_inst_valid[1] = (count ≥ 2).
  - Slot 0 shows entry[head]; slot 1 shows entry[head+1 mod DEPTH].
  - The payload of an invalid slot is forced to 0.
- Dequeue: when !out_stall && !flush, head and count advance by popcount(out_inst_valid).
- Simultaneous enqueue and dequeue: count_next = count + n_enq − n_deq. Full throughput is 2 in and 2 out per cycle.
- flush has priority over enqueue and dequeue:
  - Next cycle head = tail = count = 0 and out_inst_valid = 0.
  - The input bundle presented in the flush cycle is dropped.
  - Flush during out_stall behaves the same way.
- Latency: an instruction enqueued in cycle N is visible at the output in cycle N+1 at the earliest (no bypass unless the optional feature is enabled).
- Ordering: strict program order. The pointer wrap DEPTH−1 → 0 is seamless, including a 2-entry write or read straddling the wrap.
- count never exceeds DEPTH and never goes below 0. The verification bench asserts both.

Optional Feature:
- Macro: DECODE_QUEUE_BYPASS_EN.
- Defined:
  - Condition: count == 0, !out_stall, !flush, and the input bundle is valid.
  - Effect: the compacted bundle drives the out_* ports directly in the same cycle, and no storage is written.
  - Zero-cycle latency when empty. in_ready is unchanged.
- Undefined: no bypass path; minimum latency is 1 cycle.

Decomposition:
- Shared package / riscv_define.v:
  - Fetch-entry field widths, already given by `INST_WIDTH`, `INST_ADDR_WIDTH`, `BP_GHR_BITS`, `IF_BATCH_SIZE`.
  - A packed FETCH_ENTRY_WIDTH constant.
  - The default DEPTH as `DECODE_QUEUE_DEPTH`.
- One sub-module: decode_queue_compact.
  - Combinational: takes the 2-slot bundle plus mask and produces the compacted entry pair and the enqueue count.
  - Reused by the bypass path.

Test Plan:
- Reset mid-run with count = 5 → same cycle: count = 0, out_inst_valid = 2'b00, in_ready = 1.
- Enqueue mask 2'b10 with pc_1 = 0x104 into an empty queue, out_stall = 1 → next cycle out_inst_valid = 2'b01, out_pc_0 = 0x104, count = 1.
- Hold out_stall = 1 and push four 2'b11 bundles (PCs 0x0..0x1C) → count = 8, in_ready = 0. A fifth bundle is ignored; releasing out_stall drains 0x0, 0x4, … in order, 2 per cycle.
- DEPTH = 8 with head = 7 and count = 2 → slot 0 shows entry 7, slot 1 shows entry 0. Dequeue gives head = 1, count = 0.
- Assert flush with count = 6 while presenting a valid 2'b11 bundle → next cycle count = 0, out_inst_valid = 0. The flushed bundle never appears.
- With count = 3, simultaneous enqueue 2'b11 and dequeue 2 → count = 3, and output order is preserved.
- Bypass case (DECODE_QUEUE_BYPASS_EN, empty queue, bundle 2'b11 at pc 0x200) → same-cycle out_pc_0 = 0x200, out_pc_1 = 0x204, count stays 0.
